bmc_encoder: RTL and testbench



---
 rtl/bmc_pkg.sv | 6 +
 rtl/bmc_half_bit_timer.sv | 26 ++
 rtl/bmc_encoder.sv | 102 ++++++++++
 tb/tb_bmc_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bmc_pkg.sv
// bmc_pkg: shared state encoding and frame constants for the BMC encoder and decoder
package bmc_pkg;
   typedef enum logic [1:0] {IDLE, LEAD, DATA, TAIL} bmc_state_t;
   localparam int BMC_BIT_COUNT = 17;
   localparam int TS_WIDTH = 24;
endpackage

// File: rtl/bmc_half_bit_timer.sv
// bmc_half_bit_timer: half-bit pacing with a first/second-half phase flag
module bmc_half_bit_timer #(
   parameter int CLKS_PER_HALF_BIT = 8
) (
   input  logic clk_96MHz,
   input  logic reset,
   input  logic en,
   output logic half_tick,
   output logic phase
);
   localparam int W = CLKS_PER_HALF_BIT > 1 ? $clog2(CLKS_PER_HALF_BIT) : 1;
   logic [W-1:0] cnt;
   assign half_tick = en && cnt == W'(CLKS_PER_HALF_BIT - 1);
   // count half-bit cycles while enabled; phase flips at every half-bit end, both clear when idle
   always_ff @(posedge clk_96MHz or posedge reset)
      if (reset) begin
         cnt <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         phase <= 1'b0;
      end else begin
         cnt <= half_tick ? '0 : cnt + 1'b1;
         phase <= phase ^ half_tick;
      end
endmodule

// File: rtl/bmc_encoder.sv
// bmc_encoder: sends a handshaked word as an envelope-framed biphase-mark stream
module bmc_encoder
   import bmc_pkg::*;
#(
   parameter int BIT_COUNT = BMC_BIT_COUNT,
   parameter int CLKS_PER_HALF_BIT = 8,
   parameter int LEAD_CYCLES = 48,
   parameter int TAIL_CYCLES = 16
) (
   input  logic                 clk_96MHz,
   input  logic                 reset,
   input  logic                 enabled,
   input  logic [BIT_COUNT-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [TS_WIDTH-1:0]  sys_ts,
   output logic                 e_out,
   output logic                 d_out,
   output logic                 d_out_n,
   output logic                 busy,
   output logic                 done,
   output logic [TS_WIDTH-1:0]  ts_sent
);
   localparam int LT_MAX = LEAD_CYCLES > TAIL_CYCLES ? LEAD_CYCLES : TAIL_CYCLES;
   localparam int LTW = LT_MAX > 1 ? $clog2(LT_MAX) : 1;
   localparam int BW = $clog2(BIT_COUNT + 1);
   bmc_state_t state, state_nx;
   logic [BIT_COUNT-1:0] sr;
   logic [BW-1:0] bit_cnt;
   logic [LTW-1:0] lt_cnt;
   logic half_tick, phase;
   logic accept, lead_end, tail_end, mid, bound, last_bit;
   logic ready_nx, e_nx, d_nx, dn_nx, busy_nx, done_nx;
   assign accept = state == IDLE && tx_valid && tx_ready;
   assign lead_end = state == LEAD && lt_cnt == LTW'(LEAD_CYCLES - 1);
   assign tail_end = state == TAIL && lt_cnt == LTW'(TAIL_CYCLES - 1);
   assign mid = state == DATA && half_tick && !phase;
   assign bound = state == DATA && half_tick && phase;
   assign last_bit = bit_cnt == BW'(BIT_COUNT - 1);
   bmc_half_bit_timer #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_timer (
      .clk_96MHz(clk_96MHz),
      .reset(reset),
      .en(state == DATA),
      .half_tick(half_tick),
      .phase(phase)
   );
   // state register
   always_ff @(posedge clk_96MHz or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   // frame sequencing: accept, lead-in, data bits, tail
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = LEAD;
         LEAD: if (lead_end) state_nx = DATA;
         DATA: if (bound && last_bit) state_nx = TAIL;
         TAIL: if (tail_end) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // next output values: line toggles at every boundary after the lead and mid-bit for a '1'
   always_comb begin
      e_nx = state_nx != IDLE;
      busy_nx = state_nx != IDLE;
      ready_nx = state_nx == IDLE && enabled;
      done_nx = tail_end;
      d_nx = !e_nx ? 1'b0 : (lead_end || (bound && !last_bit) || (mid && sr[BIT_COUNT-1])) ? ~d_out : d_out;
      dn_nx = e_nx && !d_nx;
   end
   // registered outputs
   always_ff @(posedge clk_96MHz or posedge reset)
      if (reset) begin
         tx_ready <= 1'b0;
         e_out <= 1'b0;
         d_out <= 1'b0;
         d_out_n <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         tx_ready <= ready_nx;
         e_out <= e_nx;
         d_out <= d_nx;
         d_out_n <= dn_nx;
         busy <= busy_nx;
         done <= done_nx;
      end
   // shift register, bit and lead/tail counters, first-boundary timestamp
   always_ff @(posedge clk_96MHz or posedge reset)
      if (reset) begin
         sr <= '0;
         bit_cnt <= '0;
         lt_cnt <= '0;
         ts_sent <= '0;
      end else begin
         if (accept) sr <= tx_data;
         else if (bound) sr <= sr << 1;
         bit_cnt <= state != DATA ? '0 : bound ? bit_cnt + 1'b1 : bit_cnt;
         lt_cnt <= (state_nx == state && (state == LEAD || state == TAIL)) ? lt_cnt + 1'b1 : '0;
         if (lead_end) ts_sent <= sys_ts;
      end
endmodule

// File: tb/tb_bmc_encoder.sv
// tb_bmc_encoder: scoreboard bench comparing encoded frames against a per-cycle line model
module tb_bmc_encoder;
   localparam int BC = 17, H = 8, LEAD = 48, TAIL = 16;
   localparam int FRAME = LEAD + 2 * BC * H + TAIL;
   typedef struct {
      logic [BC-1:0] w;
      logic [23:0]   ts;
      bit            gap1;
   } exp_t;
   logic clk = 0, reset = 1, enabled = 0, tx_valid = 0;
   logic [BC-1:0] tx_data = '0;
   logic [23:0] sys_ts = 24'h0000F0;
   logic tx_ready, e_out, d_out, d_out_n, busy, done;
   logic [23:0] ts_sent;
   exp_t sb[$];
   exp_t cur;
   int n_vec = 0, n_err = 0;
   logic [FRAME-1:0] act_tr;
   int n = 0, low = 0, gap = 0, shape = 0;
   bit in_fr = 0;
   logic [BC-1:0] rw;
   int bad;

   always #5 clk = ~clk;
   always @(posedge clk) sys_ts <= sys_ts + 24'd1;

   bmc_encoder dut (
      .clk_96MHz(clk), .reset(reset), .enabled(enabled), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .sys_ts(sys_ts), .e_out(e_out),
      .d_out(d_out), .d_out_n(d_out_n), .busy(busy), .done(done), .ts_sent(ts_sent)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // line level per envelope cycle: 0 during lead, flip at each bit start, extra flip mid-bit for a 1
   function automatic logic [FRAME-1:0] model(input logic [BC-1:0] w);
      logic [FRAME-1:0] r = '0;
      logic lvl = 1'b0;
      int t;
      for (int i = 0; i < FRAME; i++) begin
         t = i - LEAD;
         if (t >= 0 && t < BC * 2 * H) begin
            if (t % (2 * H) == 0) lvl = ~lvl;
            else if (t % (2 * H) == H && w[BC - 1 - t / (2 * H)]) lvl = ~lvl;
         end
         r[i] = lvl;
      end
      return r;
   endfunction

   // monitor: record each envelope, check it against the oldest expected frame when it closes
   always @(negedge clk) begin
      if (reset) begin
         in_fr = 0;
         low = 0;
      end else if (e_out) begin
         if (!in_fr) begin
            in_fr = 1;
            n = 0;
            shape = 0;
            act_tr = '0;
            gap = low;
         end
         if (n < FRAME) act_tr[n] = d_out;
         n++;
         if (d_out_n !== ~d_out || busy !== 1'b1 || done !== 1'b0 || tx_ready !== 1'b0) shape++;
      end else if (in_fr) begin
         in_fr = 0;
         low = 1;
         if (sb.size() == 0) chk("unexpected_frame", 1, 0);
         else begin
            cur = sb.pop_front();
            chk("frame_len", n, FRAME);
            chk("d_trace_bits_wrong", $countones(act_tr ^ model(cur.w)), 0);
            chk("edges", $countones(act_tr ^ (act_tr << 1)), BC + $countones(cur.w));
            chk("in_frame_shape", shape, 0);
            chk("ts_sent", ts_sent, cur.ts);
            chk("done_at_end", done, 1);
            chk("busy_at_end", busy, 0);
            chk("lines_at_end", {d_out, d_out_n}, 0);
            if (cur.gap1) chk("b2b_gap", gap, 1);
         end
      end else begin
         low++;
         if (low == 2) chk("done_one_cycle", done, 0);
      end
   end

   task automatic send(input logic [BC-1:0] w, input bit keep, input bit gap1);
      bit ok = 0;
      enabled = 1;
      tx_data = w;
      tx_valid = 1;
      for (int i = 0; i < 4 * FRAME && !ok; i++) begin
         if (tx_ready) begin
            sb.push_back('{w, sys_ts + 24'(LEAD), gap1});
            ok = 1;
         end else @(negedge clk);
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(negedge clk);
      if (!keep) tx_valid = 0;
   endtask

   task automatic drain();
      int i = 0;
      while ((sb.size() != 0 || e_out) && i < 4 * FRAME) begin
         @(negedge clk);
         i++;
      end
      chk("drain", sb.size() == 0 && !e_out, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #3;
      chk("reset_outputs", {tx_ready, e_out, d_out, d_out_n, busy, done, ts_sent}, 0);
      @(negedge clk);
      @(negedge clk);
      enabled = 1;
      reset = 0;
      @(negedge clk);
      chk("ready_after_release", tx_ready, 1);
      send(17'h1_5555, 0, 0);
      send(17'h0_0000, 0, 0);
      send(17'h0_ABCD, 0, 0);
      send(17'h1_FFFF, 1, 0);
      send(17'h0_1234, 0, 1);
      drain();
      repeat (8) begin
         rw = BC'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send(rw, 0, 0);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            enabled = 0;
         end
      end
      drain();
      rw = BC'($urandom);
      send(rw, 0, 0);
      repeat (199) @(negedge clk);
      #2 reset = 1;
      #1 chk("reset_mid_frame", {tx_ready, e_out, d_out, d_out_n, busy, done, ts_sent}, 0);
      sb.delete();
      repeat (3) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("ready_after_mid_reset", tx_ready, 1);
      send(BC'($urandom), 0, 0);
      drain();
      enabled = 0;
      @(negedge clk);
      @(negedge clk);
      tx_data = BC'($urandom);
      tx_valid = 1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx_ready || e_out) bad++;
      end
      chk("disabled_no_accept", bad, 0);
      tx_valid = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
